collision_event_hub: RTL and testbench

- Parametrised successor of the per-frame collision controller.
- Evaluates a table of NUM_RULES object-pair collision rules against NUM_OBJ per-pixel drawing requests.
- Per rule, produces a level collision, a single pulse per frame, and a previous-frame summary.
- Serialises fired rule IDs into a small event FIFO with a valid/ready handshake, so the game-logic sequencer can consume events one at a time.

---
 rtl/collision_event_hub.sv | 198 +++++++++++++++++++
 tb/tb_collision_event_hub.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_event_hub.sv
`default_nettype none
// ============================================================================
//  Module      : collision_event_hub
//  Description : Evaluates a table of object-pair collision rules against the
//                per-pixel drawing requests. For every rule it produces a
//                combinational collision level, a registered once-per-frame
//                hit pulse and a summary of the rules that fired during the
//                previous frame. Fired rule IDs are queued into a small event
//                FIFO with a valid/ready handshake so a sequencer can consume
//                them one at a time.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1          system clock
//    resetN          in   1          asynchronous active-low reset
//    startOfFrame    in   1          one-cycle pulse at frame start
//    draw_req        in   NUM_OBJ    per-object drawing request
//    rule_enable     in   NUM_RULES  per-rule enable
//    collision_level out  NUM_RULES  combinational overlap per rule
//    hit_pulse       out  NUM_RULES  first overlap of a rule in a frame
//    frame_hits      out  NUM_RULES  rules that fired in the previous frame
//    evt_valid       out  1          event FIFO head valid
//    evt_id          out  ID_W       rule index at the FIFO head
//    evt_ready       in   1          consumer accepts the head
//    evt_overflow    out  1          sticky: an event was merged
//    evt_ovf_clr     in   1          clears evt_overflow
// ============================================================================
module collision_event_hub #(
    parameter int NUM_OBJ    = 9,
    parameter int NUM_RULES  = 9,
    parameter int OBJ_W      = $clog2(NUM_OBJ),
    // Rule r uses bits [r*OBJ_W +: OBJ_W]; listed below from rule 8 down to 0.
    // Objects: 0 char, 1 explosion, 2 bomb, 3 wall, 4 boots, 5 life,
    //          6 addBomb, 7 landMine, 8 explosionMine.
    parameter logic [NUM_RULES*OBJ_W-1:0] RULE_A = {
        OBJ_W'(8), OBJ_W'(7), OBJ_W'(8), OBJ_W'(0), OBJ_W'(1),
        OBJ_W'(0), OBJ_W'(0), OBJ_W'(0), OBJ_W'(0)
    },
    parameter logic [NUM_RULES*OBJ_W-1:0] RULE_B = {
        OBJ_W'(0), OBJ_W'(0), OBJ_W'(1), OBJ_W'(1), OBJ_W'(3),
        OBJ_W'(6), OBJ_W'(5), OBJ_W'(4), OBJ_W'(3)
    },
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic [NUM_OBJ-1:0]            draw_req,
    input  logic [NUM_RULES-1:0]          rule_enable,
    output logic [NUM_RULES-1:0]          collision_level,
    output logic [NUM_RULES-1:0]          hit_pulse,
    output logic [NUM_RULES-1:0]          frame_hits,
    output logic                          evt_valid,
    output logic [$clog2(NUM_RULES)-1:0]  evt_id,
    input  logic                          evt_ready,
    output logic                          evt_overflow,
    input  logic                          evt_ovf_clr
);

    localparam int ID_W  = $clog2(NUM_RULES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [NUM_RULES-1:0] r_flag;        // rule already fired in this frame
    logic [NUM_RULES-1:0] r_hit;
    logic [NUM_RULES-1:0] r_frame_hits;
    logic [NUM_RULES-1:0] r_pending;     // fired, not yet pushed into the FIFO
    logic                 r_overflow;
    logic [ID_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;       // 0..FIFO_DEPTH, separates full/empty

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [NUM_RULES-1:0] w_flag_eff;
    logic [NUM_RULES-1:0] w_set;
    logic [NUM_RULES-1:0] w_push_oh;
    logic [NUM_RULES-1:0] w_push_clr;
    logic [ID_W-1:0]      w_push_id;
    logic                 w_push_any;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_merge;

    // ------------------------------------------------------------------------
    // Rule evaluation. Rules whose object index lies outside the request
    // vector can never overlap and are tied low.
    // ------------------------------------------------------------------------
    for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
        localparam int c_obj_a = int'(RULE_A[r*OBJ_W +: OBJ_W]);
        localparam int c_obj_b = int'(RULE_B[r*OBJ_W +: OBJ_W]);
        if ((c_obj_a < NUM_OBJ) && (c_obj_b < NUM_OBJ)) begin : g_valid
            assign collision_level[r] = rule_enable[r]
                                      & draw_req[c_obj_a]
                                      & draw_req[c_obj_b];
        end else begin : g_invalid
            assign collision_level[r] = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // The frame clear is applied before the overlap test, so an overlap
        // in the startOfFrame cycle is counted for the new frame.
        w_flag_eff = startOfFrame ? '0 : r_flag;
        w_set      = collision_level & ~w_flag_eff;

        w_full     = (r_count == CNT_W'(FIFO_DEPTH));
        w_pop      = evt_valid & evt_ready;

        // Lowest-index pending rule is the push candidate.
        w_push_any = 1'b0;
        w_push_id  = '0;
        w_push_oh  = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_push_any = 1'b1;
                w_push_id  = ID_W'(i);
                w_push_oh  = NUM_RULES'(1) << i;
            end
        end

        // A full FIFO still accepts a push when its head leaves this cycle.
        w_push     = w_push_any & (~w_full | w_pop);
        w_push_clr = w_push ? w_push_oh : '0;

        // A new hit on a rule whose previous event is still waiting (and is
        // not leaving this cycle) collapses into one event.
        w_merge    = |(w_set & r_pending & ~w_push_clr);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_flag       <= '0;
            r_hit        <= '0;
            r_frame_hits <= '0;
            r_pending    <= '0;
            r_overflow   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_hit     <= w_set;
            r_flag    <= w_flag_eff | collision_level;
            if (startOfFrame) begin
                r_frame_hits <= r_flag;
            end

            r_pending <= (r_pending & ~w_push_clr) | w_set;

            // Setting wins over a simultaneous clear.
            if (w_merge) begin
                r_overflow <= 1'b1;
            end else if (evt_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hit_pulse    = r_hit;
    assign frame_hits   = r_frame_hits;
    assign evt_overflow = r_overflow;
    assign evt_valid    = (r_count != '0);
    assign evt_id       = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_collision_event_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_event_hub
//  Description : Self-checking bench for collision_event_hub with directed
//                scenarios followed by randomized traffic, all compared
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_event_hub;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic [8:0] draw_req;
    logic [8:0] rule_enable;
    logic [8:0] collision_level;
    logic [8:0] hit_pulse;
    logic [8:0] frame_hits;
    logic       evt_valid;
    logic [3:0] evt_id;
    logic       evt_ready;
    logic       evt_overflow;
    logic       evt_ovf_clr;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Default rule table: object pairs per rule
    int RA [9] = '{0, 0, 0, 0, 1, 0, 8, 7, 8};
    int RB [9] = '{3, 4, 5, 6, 3, 1, 1, 0, 0};

    // Reference model state
    bit m_flag [9];
    bit m_pend [9];
    bit m_fh   [9];
    bit m_hit  [9];
    bit m_ovf;
    int q [$];

    collision_event_hub dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .draw_req        (draw_req),
        .rule_enable     (rule_enable),
        .collision_level (collision_level),
        .hit_pulse       (hit_pulse),
        .frame_hits      (frame_hits),
        .evt_valid       (evt_valid),
        .evt_id          (evt_id),
        .evt_ready       (evt_ready),
        .evt_overflow    (evt_overflow),
        .evt_ovf_clr     (evt_ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] pk(input bit a [9]);
        logic [8:0] v;
        for (int i = 0; i < 9; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic logic [8:0] mask2(input int a, input int b);
        logic [8:0] v;
        v = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [8:0] exp_level();
        logic [8:0] e;
        for (int r = 0; r < 9; r++)
            e[r] = rule_enable[r] & draw_req[RA[r]] & draw_req[RB[r]];
        return e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 9; r++) begin
            m_flag[r] = 0; m_pend[r] = 0; m_fh[r] = 0; m_hit[r] = 0;
        end
        m_ovf = 0;
        q.delete();
    endtask

    // One clock edge of the reference behaviour, using the inputs present
    // just before the edge.
    task automatic model_edge();
        logic [8:0] lvl;
        bit         set_v [9];
        bit         pop, merged;
        int         push_r;
        lvl    = exp_level();
        pop    = (q.size() > 0) && evt_ready;
        push_r = -1;
        if (q.size() < 4 || pop) begin
            for (int r = 8; r >= 0; r--) if (m_pend[r]) push_r = r;
        end
        merged = 0;
        for (int r = 0; r < 9; r++) begin
            set_v[r] = lvl[r] && !(startOfFrame ? 1'b0 : m_flag[r]);
            if (set_v[r] && m_pend[r] && r != push_r) merged = 1;
        end
        if (merged) m_ovf = 1;
        else if (evt_ovf_clr) m_ovf = 0;
        if (pop) void'(q.pop_front());
        if (push_r >= 0) begin
            q.push_back(push_r);
            m_pend[push_r] = 0;
        end
        for (int r = 0; r < 9; r++) begin
            if (startOfFrame) m_fh[r] = m_flag[r];
            m_flag[r] = (startOfFrame ? 1'b0 : m_flag[r]) | lvl[r];
            m_hit[r]  = set_v[r];
            if (set_v[r]) m_pend[r] = 1;
        end
    endtask

    task automatic check_outputs();
        check("hit_pulse",    hit_pulse,    pk(m_hit));
        check("frame_hits",   frame_hits,   pk(m_fh));
        check("evt_valid",    evt_valid,    q.size() > 0);
        if (q.size() > 0) check("evt_id", evt_id, q[0]);
        check("evt_overflow", evt_overflow, m_ovf);
    endtask

    task automatic step();
        #1;
        check("collision_level", collision_level, exp_level());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic fire(input int r);
        draw_req = mask2(RA[r], RB[r]);
        step();
        draw_req = '0;
    endtask

    task automatic sof_step();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq3 [6] = '{0, 1, 2, 3, 4, 6};
        int seq2 [4] = '{0, 1, 4, 5};

        resetN       = 1'b0;
        startOfFrame = 1'b0;
        draw_req     = '0;
        rule_enable  = '1;
        evt_ready    = 1'b0;
        evt_ovf_clr  = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_hit_pulse",  hit_pulse,    9'h0);
        check("rst_frame_hits", frame_hits,   9'h0);
        check("rst_evt_valid",  evt_valid,    1'b0);
        check("rst_evt_id",     evt_id,       4'h0);
        check("rst_overflow",   evt_overflow, 1'b0);
        @(negedge clk);
        resetN = 1'b1;

        // 1: char/wall for three cycles
        sof_step();
        draw_req = mask2(0, 3);
        step();
        check("t1_pulse_first", hit_pulse[0], 1'b1);
        check("t1_valid_early", evt_valid, 1'b0);
        step();
        check("t1_pulse_once", hit_pulse[0], 1'b0);
        check("t1_valid", evt_valid, 1'b1);
        check("t1_id", evt_id, 4'd0);
        step();
        check("t1_level_third", collision_level[0], 1'b1);
        draw_req  = '0;
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        sof_step();
        check("t1_frame_hits", frame_hits, 9'b000000001);

        // 2: char, wall, boots, explosion together; explosion/wall (rule 4)
        //    also overlaps, so the head sequence is 0, 1, 4, 5
        evt_ready = 1'b1;
        draw_req  = 9'b000011011;
        step();
        draw_req = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_id_seq", evt_id, seq2[k]);
        end
        step();
        check("t2_drained", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // 3: six rules with the consumer stalled
        sof_step();
        for (int k = 0; k < 6; k++) fire(seq3[k]);
        step();
        step();
        check("t3_valid", evt_valid, 1'b1);
        check("t3_no_ovf", evt_overflow, 1'b0);
        evt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("t3_drain_id", evt_id, seq3[k]);
            step();
        end
        check("t3_drained", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // 4: rule 2 re-fires in the next frame while still pending
        sof_step();
        fire(0); fire(1); fire(3); fire(4);
        fire(2);
        step();
        check("t4_ovf_before", evt_overflow, 1'b0);
        sof_step();
        fire(2);
        check("t4_ovf_set", evt_overflow, 1'b1);
        evt_ovf_clr = 1'b1;
        step();
        evt_ovf_clr = 1'b0;
        check("t4_ovf_clr", evt_overflow, 1'b0);
        evt_ready = 1'b1;
        repeat (7) step();
        check("t4_drained", evt_valid, 1'b0);

        // 5: overlap in the startOfFrame cycle
        startOfFrame = 1'b1;
        draw_req     = mask2(0, 3);
        step();
        startOfFrame = 1'b0;
        check("t5_pulse", hit_pulse[0], 1'b1);
        check("t5_frame_hits", frame_hits, 9'b000000100);
        draw_req = '0;
        step();
        fire(0);
        check("t5_no_second_pulse", hit_pulse[0], 1'b0);
        repeat (3) step();

        // 6: disabled rule, then reset while draining
        rule_enable = 9'h1FE;
        draw_req    = mask2(0, 3);
        #1;
        check("t6_level_disabled", collision_level[0], 1'b0);
        step();
        check("t6_no_pulse", hit_pulse[0], 1'b0);
        draw_req = '0;
        step();
        check("t6_no_event", evt_valid, 1'b0);
        rule_enable = '1;
        sof_step();
        evt_ready = 1'b0;
        draw_req  = 9'b001110001;
        step();
        draw_req  = '0;
        step();
        evt_ready = 1'b1;
        step();
        check("t6_mid_drain", evt_valid, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        check("t6_rst_valid",      evt_valid,    1'b0);
        check("t6_rst_id",         evt_id,       4'h0);
        check("t6_rst_hit",        hit_pulse,    9'h0);
        check("t6_rst_frame_hits", frame_hits,   9'h0);
        check("t6_rst_ovf",        evt_overflow, 1'b0);
        model_reset();
        @(negedge clk);
        resetN    = 1'b1;
        evt_ready = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 9; b++) draw_req[b] = ($urandom_range(0, 4) == 0);
            rule_enable  = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'h1FF;
            evt_ready    = ($urandom_range(0, 2) != 0);
            startOfFrame = ($urandom_range(0, 15) == 0);
            evt_ovf_clr  = ($urandom_range(0, 19) == 0);
            step();
        end
        draw_req     = '0;
        startOfFrame = 1'b0;
        evt_ovf_clr  = 1'b0;
        evt_ready    = 1'b1;
        repeat (12) step();
        check("final_drained", evt_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
